spi_slave_regs: RTL and testbench

SPI responder for the SPI master's register-configuration frames. Oversamples the serial link on the system clock, decodes tag, address and data phases, and holds a bank of 32-bit configuration registers. Write frames update a register; read frames shift a register back to the master. Sits on the peripheral side of the link and feeds its register bank to downstream logic such as the DDS control path.

---
 rtl/spi_slave_regs.sv | 218 +++++++++++++++++++++
 tb/tb_spi_slave_regs.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs.sv
// SPI responder holding a bank of 32-bit configuration registers.
// The serial link is oversampled on clk; write frames load a register, read frames shift one back.
module spi_slave_regs #(
  parameter int          NUM_REGS = 3,
  parameter logic [31:0] REG_INIT = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_sck,
  input  logic                    spi_cs,
  input  logic                    spi_sdi,
  output logic                    spi_sdo,
  output logic                    spi_sdo_oe,
  output logic [32*NUM_REGS-1:0]  regs_o,
  output logic                    wr_stb,
  output logic [7:0]              wr_addr,
  output logic                    rd_stb,
  output logic                    addr_err,
  output logic                    frame_err,
  output logic [2:0]              fsm_state
);

  // fsm_state is a debug view of the frame decoder; encoding follows the enum order below.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TAG   = 3'd1,
    S_ADDR  = 3'd2,
    S_WDATA = 3'd3,
    S_TURN  = 3'd4,
    S_RDATA = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state;
  logic [1:0]  sck_sync;
  logic [1:0]  cs_sync;
  logic [1:0]  sdi_sync;
  logic        sck_q;
  logic        cs_q;
  logic        sck;
  logic        cs;
  logic        sdi;
  logic        sck_rise;
  logic        sck_fall;
  logic        cs_fall;
  logic [5:0]  bit_cnt;
  logic        is_read;
  logic [7:0]  addr;
  logic [7:0]  addr_next;
  logic        addr_next_ok;
  logic        addr_ok;
  logic [31:0] wdata;
  logic [31:0] wdata_next;
  logic [31:0] shreg;
  logic [31:0] rd_word;
  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= 2'b00;
      cs_sync  <= 2'b00;
      sdi_sync <= 2'b00;
      sck_q    <= 1'b0;
      cs_q     <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], spi_sck};
      cs_sync  <= {cs_sync[0], spi_cs};
      sdi_sync <= {sdi_sync[0], spi_sdi};
      sck_q    <= sck_sync[1];
      cs_q     <= cs_sync[1];
    end
  end

  assign sck        = sck_sync[1];
  assign cs         = cs_sync[1];
  assign sdi        = sdi_sync[1];
  assign sck_rise   = sck & ~sck_q;
  assign sck_fall   = ~sck & sck_q;
  assign cs_fall    = ~cs & cs_q;
  assign addr_next  = {addr[6:0], sdi};
  assign wdata_next = {wdata[30:0], sdi};
  assign addr_next_ok = (addr_next < 8'(NUM_REGS));
  assign addr_ok      = (addr < 8'(NUM_REGS));
  assign fsm_state  = state;

  // Out-of-range reads return zero.
  always_comb begin
    rd_word = 32'h0000_0000;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr_next == 8'(k)) rd_word = regs[k];
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_o[32*k +: 32] = regs[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= 6'd0;
      is_read    <= 1'b0;
      addr       <= 8'h00;
      wdata      <= 32'h0000_0000;
      shreg      <= 32'h0000_0000;
      spi_sdo    <= 1'b0;
      spi_sdo_oe <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= 8'h00;
      rd_stb     <= 1'b0;
      addr_err   <= 1'b0;
      frame_err  <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= REG_INIT;
    end else begin
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      addr_err  <= 1'b0;
      frame_err <= 1'b0;
      if (!cs) begin
        if (cs_fall && state != S_IDLE && state != S_DONE) frame_err <= 1'b1;
        state      <= S_IDLE;
        bit_cnt    <= 6'd0;
        spi_sdo    <= 1'b0;
        spi_sdo_oe <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state   <= S_TAG;
            bit_cnt <= 6'd0;
          end
          S_TAG: begin
            if (sck_fall) begin
              is_read <= sdi;
              state   <= S_ADDR;
              bit_cnt <= 6'd0;
            end
          end
          S_ADDR: begin
            if (sck_fall) begin
              addr <= addr_next;
              if (bit_cnt == 6'd7) begin
                bit_cnt  <= 6'd0;
                addr_err <= ~addr_next_ok;
                if (is_read) begin
                  state      <= S_TURN;
                  shreg      <= rd_word;
                  rd_stb     <= 1'b1;
                  spi_sdo    <= 1'b0;
                  spi_sdo_oe <= 1'b1;
                end else begin
                  state <= S_WDATA;
                end
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
          S_WDATA: begin
            if (sck_fall) begin
              wdata <= wdata_next;
              if (bit_cnt == 6'd31) begin
                state   <= S_DONE;
                bit_cnt <= 6'd0;
                if (addr_ok) begin
                  for (int k = 0; k < NUM_REGS; k++) begin
                    if (addr == 8'(k)) regs[k] <= wdata_next;
                  end
                  wr_stb  <= 1'b1;
                  wr_addr <= addr;
                end
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
          S_TURN: begin
            if (sck_fall) begin
              if (bit_cnt == 6'd1) begin
                state   <= S_RDATA;
                bit_cnt <= 6'd0;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
          S_RDATA: begin
            // The master samples on its falling edge, so the next bit goes out on each rise.
            if (sck_rise) begin
              spi_sdo <= shreg[31];
              shreg   <= {shreg[30:0], 1'b0};
            end
            if (sck_fall) begin
              if (bit_cnt == 6'd31) begin
                state      <= S_DONE;
                bit_cnt    <= 6'd0;
                spi_sdo    <= 1'b0;
                spi_sdo_oe <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
          S_DONE: begin
            spi_sdo    <= 1'b0;
            spi_sdo_oe <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed and randomized frames for spi_slave_regs, checked against a register-bank model.
// A bit-banging master drives sck at clk/32 and shifts read data in on its falling edges.
module tb_spi_slave_regs;

  localparam int          NREGS    = 3;
  localparam logic [31:0] RINIT    = 32'h1357_9bdf;
  localparam int          HALF     = 16;
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_RDATA = 3'd5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  spi_sck = 1'b0;
  logic                  spi_cs = 1'b0;
  logic                  spi_sdi = 1'b0;
  logic                  spi_sdo;
  logic                  spi_sdo_oe;
  logic [32*NREGS-1:0]   regs_o;
  logic                  wr_stb;
  logic [7:0]            wr_addr;
  logic                  rd_stb;
  logic                  addr_err;
  logic                  frame_err;
  logic [2:0]            fsm_state;

  spi_slave_regs #(.NUM_REGS(NREGS), .REG_INIT(RINIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_cs     (spi_cs),
    .spi_sdi    (spi_sdi),
    .spi_sdo    (spi_sdo),
    .spi_sdo_oe (spi_sdo_oe),
    .regs_o     (regs_o),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr),
    .rd_stb     (rd_stb),
    .addr_err   (addr_err),
    .frame_err  (frame_err),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: observed no end of test, expected finish before 95000 clk");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          compared   = 0;
  int          mismatched = 0;
  int          rd_cnt     = 0;
  int          aerr_cnt   = 0;
  int          ferr_cnt   = 0;
  int          exp_rd     = 0;
  int          exp_aerr   = 0;
  int          exp_ferr   = 0;
  logic [7:0]  obs_wr_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] model [NREGS];
  logic        oe_pre;
  logic        oe_turn;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (wr_stb)    obs_wr_q.push_back(wr_addr);
      if (rd_stb)    rd_cnt++;
      if (addr_err)  aerr_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++) model[k] = RINIT;
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < NREGS; k++)
      chk($sformatf("%s_reg%0d", tag, k), regs_o[32*k +: 32], model[k]);
  endtask

  task automatic check_sb(input string tag);
    logic [7:0] e;
    logic [7:0] o;
    chk({tag, "_wr_count"}, 32'(obs_wr_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_wr_q.pop_front();
      chk({tag, "_wr_addr"}, 32'(o), 32'(e));
    end
    exp_q.delete();
    obs_wr_q.delete();
    chk({tag, "_rd_stb_count"}, 32'(rd_cnt), 32'(exp_rd));
    chk({tag, "_addr_err_count"}, 32'(aerr_cnt), 32'(exp_aerr));
    chk({tag, "_frame_err_count"}, 32'(ferr_cnt), 32'(exp_ferr));
    check_regs(tag);
  endtask

  // ---------------- driver tasks ----------------
  // stop_after < 0 sends the whole frame; hold_cs leaves cs asserted at the end.
  task automatic do_frame(input bit tag, input logic [7:0] addr, input logic [31:0] data,
                          input int stop_after, input bit hold_cs, output logic [31:0] rdata);
    int   total;
    logic b;
    total = tag ? 43 : 41;
    rdata = 32'h0;
    @(negedge clk);
    spi_cs  = 1'b1;
    spi_sck = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int n = 0; n < total; n++) begin
      if (stop_after >= 0 && n >= stop_after) break;
      if (n == 0)      b = tag;
      else if (n <= 8) b = addr[8-n];
      else if (!tag)   b = data[40-n];
      else             b = 1'b0;
      spi_sck = 1'b1;
      spi_sdi = b;
      repeat (HALF) @(negedge clk);
      if (tag && n == 8)  oe_pre  = spi_sdo_oe;
      if (tag && n == 10) oe_turn = spi_sdo_oe;
      if (tag && n >= 11) rdata = {rdata[30:0], spi_sdo};
      spi_sck = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (!hold_cs) begin
      spi_cs  = 1'b0;
      spi_sdi = 1'b0;
      repeat (2*HALF) @(negedge clk);
    end
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] unused_rd;
    do_frame(1'b0, addr, data, -1, 1'b0, unused_rd);
    if (addr < NREGS) begin
      model[addr] = data;
      exp_q.push_back(addr);
    end else begin
      exp_aerr++;
    end
  endtask

  task automatic read_reg(input string tag, input logic [7:0] addr);
    logic [31:0] expected;
    logic [31:0] got;
    expected = (addr < NREGS) ? model[addr] : 32'h0;
    do_frame(1'b1, addr, 32'h0, -1, 1'b0, got);
    exp_rd++;
    if (addr >= NREGS) exp_aerr++;
    chk({tag, "_rdata"}, got, expected);
    chk({tag, "_oe_before_snapshot"}, 32'(oe_pre), 32'd0);
    chk({tag, "_oe_in_turnaround"}, 32'(oe_turn), 32'd1);
    chk({tag, "_oe_after_frame"}, 32'(spi_sdo_oe), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] rd_dummy;
    logic [7:0]  a;
    bit          is_rd;

    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_sdo", 32'(spi_sdo), 32'd0);
    chk("reset_sdo_oe", 32'(spi_sdo_oe), 32'd0);
    chk("reset_wr_stb", 32'(wr_stb), 32'd0);
    chk("reset_rd_stb", 32'(rd_stb), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_state", 32'(fsm_state), 32'(ST_IDLE));
    check_regs("reset");

    write_reg(8'd0, 32'h0123_4567);
    check_sb("write_addr0");

    write_reg(8'd2, 32'hAAAA_AAAA);
    read_reg("read_addr2", 8'd2);
    check_sb("write_read_addr2");

    write_reg(8'd5, 32'h5555_5555);
    check_sb("write_oob");
    read_reg("read_oob", 8'd5);
    check_sb("read_oob");

    // Nine header bits plus twenty data bits, then cs drops.
    do_frame(1'b0, 8'd1, 32'hDEAD_BEEF, 29, 1'b0, rd_dummy);
    exp_ferr++;
    check_sb("abort_write");
    write_reg(8'd1, $urandom);
    check_sb("after_abort");
    read_reg("after_abort_rd", 8'd1);

    // Reset in the middle of the read-data phase.
    write_reg(8'd0, $urandom);
    do_frame(1'b1, 8'd0, 32'h0, 25, 1'b1, rd_dummy);
    exp_rd++;
    chk("midread_state", 32'(fsm_state), 32'(ST_RDATA));
    chk("midread_oe", 32'(spi_sdo_oe), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    spi_cs  = 1'b0;
    spi_sck = 1'b0;
    model_reset();
    chk("rst_sdo", 32'(spi_sdo), 32'd0);
    chk("rst_sdo_oe", 32'(spi_sdo_oe), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check_regs("rst_regs");
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2*HALF) @(negedge clk);
    check_sb("post_reset");
    write_reg(8'd0, $urandom);
    check_sb("post_reset_write");

    // Back-to-back writes with cs low for one sck period between frames.
    for (int k = 0; k < NREGS; k++) write_reg(8'(k), $urandom);
    check_sb("back_to_back");

    for (int i = 0; i < 10; i++) begin
      is_rd = 1'($urandom_range(0, 1));
      a     = 8'($urandom_range(0, 5));
      d     = $urandom;
      if (is_rd) read_reg($sformatf("rand%0d_read", i), a);
      else       write_reg(a, d);
      check_sb($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
